// File: rtl/rf_access_sequencer.sv
// Serializes one instruction's register-file traffic: operand read, operand handoff,
// result wait and writeback, so reads and writes to the file never overlap.
module rf_access_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs,
  input  logic [ADDR_WIDTH-1:0] req_rt,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  input  logic                  req_wb,
  output logic                  opnd_valid,
  input  logic                  opnd_ready,
  output logic [DATA_WIDTH-1:0] opnd_a,
  output logic [DATA_WIDTH-1:0] opnd_b,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic [ADDR_WIDTH-1:0] rf_addr_r1,
  output logic [ADDR_WIDTH-1:0] rf_addr_r2,
  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  output logic                  rf_read,
  output logic                  rf_write,
  input  logic [DATA_WIDTH-1:0] rf_data_r1,
  input  logic [DATA_WIDTH-1:0] rf_data_r2,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_CAP,
    S_OPND,
    S_WAIT_RES,
    S_WR
  } state_t;

  state_t state;
  logic   wb;

  // Every output is a flop loaded with the value belonging to the state being
  // entered, so strobes never glitch and all drop at once on reset.
  // NOTE: non-blocking assignments only here; blocking ones would let later
  // statements in this block observe half-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wb         <= 1'b0;
      req_ready  <= 1'b1;
      opnd_valid <= 1'b0;
      res_ready  <= 1'b0;
      rf_read    <= 1'b0;
      rf_write   <= 1'b0;
      busy       <= 1'b0;
      opnd_a     <= '0;
      opnd_b     <= '0;
      rf_data_w  <= '0;
      rf_addr_r1 <= '0;
      rf_addr_r2 <= '0;
      rf_addr_w  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rf_addr_r1 <= req_rs;
            rf_addr_r2 <= req_rt;
            rf_addr_w  <= req_rd;
            wb         <= req_wb;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            rf_read    <= 1'b1;
            state      <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          state <= S_RD_CAP;
        end
        // Read stays asserted a second cycle so a file with registered read
        // data has presented it by this edge.
        S_RD_CAP: begin
          opnd_a     <= rf_data_r1;
          opnd_b     <= rf_data_r2;
          rf_read    <= 1'b0;
          opnd_valid <= 1'b1;
          state      <= S_OPND;
        end
        S_OPND: begin
          if (opnd_ready) begin
            opnd_valid <= 1'b0;
            if (wb) begin
              res_ready <= 1'b1;
              state     <= S_WAIT_RES;
            end else begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            rf_data_w <= res_data;
            res_ready <= 1'b0;
            rf_write  <= !(ZERO_REG_PROTECT && (rf_addr_w == '0));
            state     <= S_WR;
          end
        end
        S_WR: begin
          rf_write  <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          opnd_valid <= 1'b0;
          res_ready  <= 1'b0;
          rf_read    <= 1'b0;
          rf_write   <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench for rf_access_sequencer: a behavioural register file, directed vector
// table, multi-cycle corner sequences and randomized traffic against a scoreboard.
module tb_rf_access_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic        req_wb;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [31:0] opnd_a, opnd_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [31:0] rf_data_w;
  logic        rf_read, rf_write;
  logic [31:0] rf_data_r1, rf_data_r2;
  logic        busy;

  rf_access_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_wb     (req_wb),
    .opnd_valid (opnd_valid),
    .opnd_ready (opnd_ready),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .rf_addr_r1 (rf_addr_r1),
    .rf_addr_r2 (rf_addr_r2),
    .rf_addr_w  (rf_addr_w),
    .rf_data_w  (rf_data_w),
    .rf_read    (rf_read),
    .rf_write   (rf_write),
    .rf_data_r1 (rf_data_r1),
    .rf_data_r2 (rf_data_r2),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h0000_1111;
    if (i == 7) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural register file: combinational read, write on the clock edge.
  logic        load;
  logic [31:0] mem [32];
  assign rf_data_r1 = mem[rf_addr_r1];
  assign rf_data_r2 = mem[rf_addr_r2];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (rf_write) begin
      mem[rf_addr_w] <= rf_data_w;
    end
  end

  int read_cnt = 0, write_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (rf_read) read_cnt++;
    if (rf_write) write_cnt++;
    if (rf_read && rf_write) overlap_cnt++;
  end

  // Scoreboard view of the register file, updated from transaction semantics.
  logic [31:0] model [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic wb, input logic [31:0] res, input int o_dly, input int r_dly,
                     output logic [31:0] a, output logic [31:0] b, output int lat_opnd);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    check("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_rs = rs; req_rt = rt; req_rd = rd; req_wb = wb;
    step();
    req_valid = 1'b0;
    lat_opnd = 1;
    while (!opnd_valid && lat_opnd < 20) begin step(); lat_opnd++; end
    check("opnd_valid_wait", opnd_valid, 1'b1);
    a = opnd_a;
    b = opnd_b;
    repeat (o_dly) step();
    opnd_ready = 1'b1;
    step();
    opnd_ready = 1'b0;
    if (wb) begin
      repeat (r_dly) step();
      check("res_ready", res_ready, 1'b1);
      res_valid = 1'b1;
      res_data  = res;
      step();
      res_valid = 1'b0;
      check("wr_strobe", rf_write, (rd != 5'd0) ? 1'b1 : 1'b0);
      check("wr_addr", rf_addr_w, rd);
      check("wr_data", rf_data_w, res);
      step();
      check("wr_one_cycle", rf_write, 1'b0);
    end
    check("req_ready_back", req_ready, 1'b1);
  endtask

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        wb;
    logic [31:0] res;
    logic [31:0] exp_a, exp_b;
    int          exp_writes;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] a, b;
    int lat, r0, w0, exp_w;

    vecs[0] = '{5'd3, 5'd7, 5'd0, 1'b0, 32'h0,           32'h0000_1111, 32'hDEAD_BEEF, 0};
    vecs[1] = '{5'd1, 5'd2, 5'd5, 1'b1, 32'hA5A5_A5A5,   32'hC0DE_0001, 32'hC0DE_0002, 1};
    vecs[2] = '{5'd5, 5'd5, 5'd0, 1'b0, 32'h0,           32'hA5A5_A5A5, 32'hA5A5_A5A5, 0};
    vecs[3] = '{5'd0, 5'd3, 5'd0, 1'b1, 32'hFFFF_FFFF,   32'hC0DE_0000, 32'h0000_1111, 0};
    vecs[4] = '{5'd0, 5'd0, 5'd0, 1'b0, 32'h0,           32'hC0DE_0000, 32'hC0DE_0000, 0};

    for (int i = 0; i < 32; i++) model[i] = init_val(i);

    rst = 1'b0; load = 1'b1;
    req_valid = 1'b0; req_rs = '0; req_rt = '0; req_rd = '0; req_wb = 1'b0;
    opnd_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    step();
    step();
    load = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_opnd_valid", opnd_valid, 1'b0);
    check("rst_res_ready", res_ready, 1'b0);
    check("rst_rf_read", rf_read, 1'b0);
    check("rst_rf_write", rf_write, 1'b0);
    check("rst_opnd_a", opnd_a, 32'h0);
    check("rst_rf_data_w", rf_data_w, 32'h0);
    check("rst_rf_addr_w", rf_addr_w, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      r0 = read_cnt;
      w0 = write_cnt;
      txn(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wb, vecs[i].res, 0, 0, a, b, lat);
      check($sformatf("vec%0d_a", i), a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), b, vecs[i].exp_b);
      check($sformatf("vec%0d_opnd_lat", i), lat, 3);
      check($sformatf("vec%0d_reads", i), read_cnt - r0, 2);
      check($sformatf("vec%0d_writes", i), write_cnt - w0, vecs[i].exp_writes);
      if (vecs[i].wb && vecs[i].rd != 5'd0) model[vecs[i].rd] = vecs[i].res;
    end
    check("r0_unchanged", mem[0], 32'hC0DE_0000);

    // Operand stall: result and a second request pending must both be ignored.
    r0 = read_cnt;
    req_valid = 1'b1; req_rs = 5'd7; req_rt = 5'd3; req_rd = 5'd9; req_wb = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("stall_opnd_valid", opnd_valid, 1'b1);
    res_valid = 1'b1; res_data = 32'h1234_5678;
    req_valid = 1'b1; req_rs = 5'd1; req_rt = 5'd1; req_rd = 5'd1; req_wb = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_a", opnd_a, 32'hDEAD_BEEF);
      check("stall_b", opnd_b, 32'h0000_1111);
      check("stall_res_ready", res_ready, 1'b0);
      check("stall_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    opnd_ready = 1'b1;
    step();
    opnd_ready = 1'b0;
    check("stall_res_ready_after", res_ready, 1'b1);
    step();
    res_valid = 1'b0;
    check("stall_wr", rf_write, 1'b1);
    check("stall_wr_addr", rf_addr_w, 5'd9);
    check("stall_wr_data", rf_data_w, 32'h1234_5678);
    step();
    check("stall_idle", req_ready, 1'b1);
    check("stall_reads", read_cnt - r0, 2);
    model[9] = 32'h1234_5678;

    // Reset while the write strobe is up: the write must never land.
    req_valid = 1'b1; req_rs = 5'd2; req_rt = 5'd4; req_rd = 5'd6; req_wb = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    opnd_ready = 1'b1;
    step();
    opnd_ready = 1'b0;
    res_valid = 1'b1; res_data = 32'hBAD0_BAD0;
    step();
    res_valid = 1'b0;
    check("mid_wr_strobe", rf_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rf_write", rf_write, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_opnd_a", opnd_a, 32'h0);
    check("mid_rst_rf_data_w", rf_data_w, 32'h0);
    check("mid_rst_rf_addr_w", rf_addr_w, 5'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    txn(5'd6, 5'd9, 5'd0, 1'b0, 32'h0, 0, 0, a, b, lat);
    check("post_rst_a", a, 32'hC0DE_0006);
    check("post_rst_b", b, 32'h1234_5678);

    // Randomized back-to-back traffic against the scoreboard.
    w0 = write_cnt;
    exp_w = 0;
    for (int t = 0; t < 1000; t++) begin
      logic [4:0]  rs, rt, rd;
      logic        wb;
      logic [31:0] res;
      rs  = 5'($urandom_range(0, 31));
      rt  = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      wb  = 1'($urandom_range(0, 1));
      res = $urandom;
      txn(rs, rt, rd, wb, res, $urandom_range(0, 2), $urandom_range(0, 2), a, b, lat);
      check("rand_a", a, model[rs]);
      check("rand_b", b, model[rt]);
      if (wb && rd != 5'd0) begin
        model[rd] = res;
        exp_w++;
      end
    end
    check("rand_writes", write_cnt - w0, exp_w);
    check("rw_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
